// File: rtl/mole_game_controller.sv
// mole_game_controller: whack-a-mole round sequencer. Picks a mole from an LFSR,
// times its exposure, scores button hits and counts the round down on 1 Hz ticks.
module mole_game_controller #(
   parameter int unsigned GAME_SECONDS = 30,
   parameter int unsigned MOLE_TICKS   = 2,
   parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       startButton,
   input  logic [4:0] moleButton,
   output logic [4:0] moleLED,
   output logic [6:0] score,
   output logic [6:0] timeLeft,
   output logic       gameActive,
   output logic       gameOver
);

   localparam int unsigned NUM_MOLES = 5;
   localparam int unsigned IDX_W     = 3;
   localparam int unsigned SCORE_W   = 7;
   localparam int unsigned TIME_W    = 7;
   localparam int unsigned TMR_W     = 4;
   localparam int unsigned LFSR_W    = 8;
   localparam int unsigned SCORE_MAX = 99;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPAWN,
      S_UP,
      S_GAP,
      S_OVER
   } state_e;

   state_e               state_q, state_d;
   logic [LFSR_W-1:0]    lfsr_q, lfsr_d;
   logic                 start_prev_q;
   logic [NUM_MOLES-1:0] btn_prev_q;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [NUM_MOLES-1:0] led_q, led_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [TIME_W-1:0]    time_q, time_d;
   logic                 active_q, active_d;
   logic                 over_q, over_d;

   logic                 start_press_c;
   logic [NUM_MOLES-1:0] btn_press_c;
   logic [IDX_W-1:0]     raw_idx_c;
   logic [IDX_W-1:0]     pick_idx_c;
   logic [NUM_MOLES-1:0] mole_mask_c;
   logic                 hit_c;
   logic                 wrong_c;
   logic                 in_round_c;

   // Rising-edge presses against the once-registered button levels.
   assign start_press_c = startButton & ~start_prev_q;
   assign btn_press_c   = moleButton & ~btn_prev_q;

   // Fibonacci LFSR, taps 8,6,5,4 (maximal length, never reaches zero from a nonzero seed).
   assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   // Fold the 3 LFSR bits onto 0..4 and step past the previous mole to avoid repeats.
   assign raw_idx_c  = (lfsr_q[2:0] >= IDX_W'(NUM_MOLES)) ? lfsr_q[2:0] - IDX_W'(NUM_MOLES)
                                                          : lfsr_q[2:0];
   assign pick_idx_c = (raw_idx_c != idx_q)                  ? raw_idx_c :
                       (raw_idx_c == IDX_W'(NUM_MOLES - 1))  ? '0
                                                             : raw_idx_c + IDX_W'(1);

   // Hit/penalty decode against the currently latched mole.
   assign mole_mask_c = NUM_MOLES'(1) << idx_q;
   assign hit_c       = |(btn_press_c & mole_mask_c);
   assign wrong_c     = |(btn_press_c & ~mole_mask_c);
   assign in_round_c  = (state_q == S_SPAWN) || (state_q == S_UP) || (state_q == S_GAP);

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      tmr_d   = tmr_q;
      led_d   = led_q;
      score_d = score_q;
      time_d  = time_q;

      unique case (state_q)
         S_IDLE, S_OVER: begin
            led_d = '0;
            if (start_press_c) begin
               score_d = '0;
               time_d  = TIME_W'(GAME_SECONDS);
               state_d = S_SPAWN;
            end
         end
         S_SPAWN: begin
            idx_d   = pick_idx_c;
            led_d   = NUM_MOLES'(1) << pick_idx_c;
            tmr_d   = TMR_W'(MOLE_TICKS);
            state_d = S_UP;
         end
         S_UP: begin
            if (hit_c) begin
               score_d = (score_q >= SCORE_W'(SCORE_MAX)) ? score_q : score_q + SCORE_W'(1);
               led_d   = '0;
               state_d = S_GAP;
            end else begin
               if (wrong_c) begin
                  score_d = (score_q == '0) ? score_q : score_q - SCORE_W'(1);
               end
               if (tick) begin
                  tmr_d = tmr_q - TMR_W'(1);
                  if (tmr_q <= TMR_W'(1)) begin
                     led_d   = '0;
                     state_d = S_GAP;
                  end
               end
            end
         end
         S_GAP: begin
            led_d = '0;
            if (tick) begin
               state_d = S_SPAWN;
            end
         end
         default: begin
            led_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      // Round countdown; expiry overrides whatever the current state chose.
      if (tick && in_round_c && (time_q != '0)) begin
         time_d = time_q - TIME_W'(1);
         if (time_q == TIME_W'(1)) begin
            led_d   = '0;
            state_d = S_OVER;
         end
      end

      active_d = (state_d == S_SPAWN) || (state_d == S_UP) || (state_d == S_GAP);
      over_d   = (state_d == S_OVER);
   end

   // Datapath and output registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr_q       <= LFSR_SEED;
         start_prev_q <= 1'b0;
         btn_prev_q   <= '0;
         idx_q        <= '0;
         tmr_q        <= '0;
         led_q        <= '0;
         score_q      <= '0;
         time_q       <= '0;
         active_q     <= 1'b0;
         over_q       <= 1'b0;
      end else begin
         lfsr_q       <= lfsr_d;
         start_prev_q <= startButton;
         btn_prev_q   <= moleButton;
         idx_q        <= idx_d;
         tmr_q        <= tmr_d;
         led_q        <= led_d;
         score_q      <= score_d;
         time_q       <= time_d;
         active_q     <= active_d;
         over_q       <= over_d;
      end
   end

   assign moleLED    = led_q;
   assign score      = score_q;
   assign timeLeft   = time_q;
   assign gameActive = active_q;
   assign gameOver   = over_q;

endmodule

// File: tb/tb_mole_game_controller.sv
// Bench for mole_game_controller: two instances (30 s and 3 s rounds) on shared
// stimulus, checked against a rule-level reference model of the game.
module tb_mole_game_controller;

   localparam int PH_IDLE  = 0;
   localparam int PH_SPAWN = 1;
   localparam int PH_UP    = 2;
   localparam int PH_GAP   = 3;
   localparam int PH_OVER  = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       startButton = 1'b0;
   logic [4:0] moleButton = 5'd0;

   logic [4:0] d_led [2];
   logic [6:0] d_sc  [2];
   logic [6:0] d_tl  [2];
   logic       d_act [2];
   logic       d_ovr [2];

   int total = 0;
   int bad = 0;

   // reference model state
   int         m_ph  [2];
   int         m_sc  [2];
   int         m_tl  [2];
   int         m_idx [2];
   int         m_tmr [2];
   logic [4:0] m_led [2];
   int         m_lfsr[2];
   logic       m_sprev;
   logic [4:0] m_bprev;

   logic [4:0] mseq [5];

   mole_game_controller #(.GAME_SECONDS(30), .MOLE_TICKS(2), .LFSR_SEED(8'hA5)) u_dut_a (
      .clock(clock), .reset(reset), .tick(tick), .startButton(startButton),
      .moleButton(moleButton), .moleLED(d_led[0]), .score(d_sc[0]), .timeLeft(d_tl[0]),
      .gameActive(d_act[0]), .gameOver(d_ovr[0]));

   mole_game_controller #(.GAME_SECONDS(3), .MOLE_TICKS(2), .LFSR_SEED(8'hA5)) u_dut_b (
      .clock(clock), .reset(reset), .tick(tick), .startButton(startButton),
      .moleButton(moleButton), .moleLED(d_led[1]), .score(d_sc[1]), .timeLeft(d_tl[1]),
      .gameActive(d_act[1]), .gameOver(d_ovr[1]));

   always #5 clock = ~clock;

   function automatic int gsec(input int k);
      return (k == 0) ? 30 : 3;
   endfunction

   function automatic logic [20:0] exp_out(input int k);
      logic act;
      act = (m_ph[k] == PH_SPAWN) || (m_ph[k] == PH_UP) || (m_ph[k] == PH_GAP);
      return {m_led[k], 7'(m_sc[k]), 7'(m_tl[k]), act, m_ph[k] == PH_OVER};
   endfunction

   // Game rules applied once per clock to both instances.
   always @(posedge clock or negedge reset) begin : ref_model
      int ph, sc, tl, idx, tmr, v, lf;
      logic [4:0] led, bp;
      logic sp;
      if (!reset) begin
         for (int k = 0; k < 2; k++) begin
            m_ph[k] <= PH_IDLE; m_sc[k] <= 0; m_tl[k] <= 0; m_idx[k] <= 0;
            m_tmr[k] <= 0; m_led[k] <= 5'd0; m_lfsr[k] <= 'hA5;
         end
         m_sprev <= 1'b0;
         m_bprev <= 5'd0;
      end else begin
         sp = startButton && !m_sprev;
         bp = moleButton & ~m_bprev;
         for (int k = 0; k < 2; k++) begin
            ph = m_ph[k]; sc = m_sc[k]; tl = m_tl[k]; idx = m_idx[k];
            tmr = m_tmr[k]; led = m_led[k]; lf = m_lfsr[k];
            case (ph)
               PH_IDLE, PH_OVER: if (sp) begin sc = 0; tl = gsec(k); ph = PH_SPAWN; end
               PH_SPAWN: begin
                  v = lf % 8;
                  if (v >= 5) v = v - 5;
                  if (v == idx) v = (v + 1) % 5;
                  idx = v; led = 5'(1 << v); tmr = 2; ph = PH_UP;
               end
               PH_UP: begin
                  if (bp[idx]) begin
                     sc = (sc < 99) ? sc + 1 : 99; led = 5'd0; ph = PH_GAP;
                  end else begin
                     if ((bp & ~led) != 5'd0) sc = (sc > 0) ? sc - 1 : 0;
                     if (tick) begin
                        tmr = tmr - 1;
                        if (tmr == 0) begin led = 5'd0; ph = PH_GAP; end
                     end
                  end
               end
               PH_GAP: if (tick) ph = PH_SPAWN;
               default: ph = PH_IDLE;
            endcase
            if (tick && (m_ph[k] == PH_SPAWN || m_ph[k] == PH_UP || m_ph[k] == PH_GAP)) begin
               tl = tl - 1;
               if (tl == 0) begin ph = PH_OVER; led = 5'd0; end
            end
            m_ph[k] <= ph; m_sc[k] <= sc; m_tl[k] <= tl; m_idx[k] <= idx;
            m_tmr[k] <= tmr; m_led[k] <= led;
            m_lfsr[k] <= ((lf * 2) % 256) + ($countones(lf & 'hB8) % 2);
         end
         m_sprev <= startButton;
         m_bprev <= moleButton;
      end
   end

   task automatic cyc(input logic s, input logic [4:0] b, input logic t);
      startButton = s;
      moleButton  = b;
      tick        = t;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [4:0] wrong_of(input logic [4:0] lit);
      return (lit == 5'b00001) ? 5'b00010 : 5'b00001;
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (10) cyc(1'b0, 5'd0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         total++;
         if ({d_led[k], d_sc[k], d_tl[k], d_act[k], d_ovr[k]} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs[%0d] got=%h want=0", k,
                     {d_led[k], d_sc[k], d_tl[k], d_act[k], d_ovr[k]});
         end
      end
   endtask

   task automatic test_start_hit();
      logic [4:0] first;
      cyc(1'b1, 5'd0, 1'b0);
      total++;
      if ({d_tl[0], d_act[0], d_led[0]} !== {7'd30, 1'b1, 5'd0}) begin
         bad++;
         $display("FAIL start_spawn got tl=%0d act=%b led=%b want tl=30 act=1 led=0",
                  d_tl[0], d_act[0], d_led[0]);
      end
      cyc(1'b0, 5'd0, 1'b0);
      first = m_led[0];
      total++;
      if ($onehot(d_led[0]) !== 1'b1 || d_led[0] !== first) begin
         bad++;
         $display("FAIL start_lit got=%b want=%b", d_led[0], first);
      end
      cyc(1'b0, first, 1'b0);
      total++;
      if ({d_sc[0], d_led[0]} !== {7'd1, 5'd0}) begin
         bad++;
         $display("FAIL first_hit got score=%0d led=%b want score=1 led=0", d_sc[0], d_led[0]);
      end
      cyc(1'b0, 5'd0, 1'b1);
      cyc(1'b0, 5'd0, 1'b0);
      total++;
      if ($onehot(d_led[0]) !== 1'b1 || d_led[0] === first || d_led[0] !== m_led[0]) begin
         bad++;
         $display("FAIL relight got=%b want=%b (prev %b)", d_led[0], m_led[0], first);
      end
   endtask

   task automatic test_miss();
      logic [4:0] lit;
      lit = m_led[0];
      cyc(1'b0, 5'd0, 1'b1);
      total++;
      if (d_led[0] !== lit) begin
         bad++;
         $display("FAIL miss_first_tick got=%b want=%b", d_led[0], lit);
      end
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b0, 5'd0, 1'b1);
      total++;
      if ({d_led[0], d_sc[0], d_tl[0]} !== {5'd0, 7'd1, 7'd27}) begin
         bad++;
         $display("FAIL miss_second_tick got led=%b score=%0d tl=%0d want led=0 score=1 tl=27",
                  d_led[0], d_sc[0], d_tl[0]);
      end
   endtask

   task automatic test_wrong();
      cyc(1'b0, 5'd0, 1'b1);
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b0, wrong_of(m_led[0]), 1'b0);
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b0, wrong_of(m_led[0]), 1'b0);
      total++;
      if ({d_sc[0], d_led[0] != 5'd0} !== {7'd0, 1'b1}) begin
         bad++;
         $display("FAIL wrong_at_zero got score=%0d led=%b want score=0 lit", d_sc[0], d_led[0]);
      end
      cyc(1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, m_led[0], 1'b0);
         cyc(1'b0, 5'd0, 1'b1);
         cyc(1'b0, 5'd0, 1'b0);
      end
      total++;
      if ({d_sc[0], d_tl[0]} !== {7'd3, 7'd23}) begin
         bad++;
         $display("FAIL three_hits got score=%0d tl=%0d want score=3 tl=23", d_sc[0], d_tl[0]);
      end
      cyc(1'b0, wrong_of(m_led[0]), 1'b0);
      total++;
      if (d_sc[0] !== 7'd2) begin
         bad++;
         $display("FAIL wrong_penalty got=%0d want=2", d_sc[0]);
      end
      cyc(1'b0, 5'd0, 1'b0);
   endtask

   task automatic test_both_held();
      logic [4:0] lit;
      lit = m_led[0];
      cyc(1'b0, lit | wrong_of(lit), 1'b0);
      total++;
      if ({d_sc[0], d_led[0]} !== {7'd3, 5'd0}) begin
         bad++;
         $display("FAIL correct_and_wrong got score=%0d led=%b want score=3 led=0", d_sc[0], d_led[0]);
      end
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b0, 5'd0, 1'b1);
      cyc(1'b0, 5'd0, 1'b0);
      lit = m_led[0];
      repeat (5) cyc(1'b0, lit, 1'b0);
      total++;
      if ({d_sc[0], d_led[0]} !== {7'd4, 5'd0}) begin
         bad++;
         $display("FAIL held_button got score=%0d led=%b want score=4 led=0", d_sc[0], d_led[0]);
      end
      cyc(1'b0, 5'd0, 1'b0);
      total++;
      if ({d_led[0], d_sc[0], d_tl[0], d_act[0], d_ovr[0]} !== exp_out(0)) begin
         bad++;
         $display("FAIL held_model got=%h want=%h",
                  {d_led[0], d_sc[0], d_tl[0], d_act[0], d_ovr[0]}, exp_out(0));
      end
   endtask

   task automatic test_game_over();
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      cyc(1'b1, 5'd0, 1'b0);
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b0, m_led[1], 1'b0);
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b0, 5'd0, 1'b1);
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b0, 5'd0, 1'b1);
      cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b0, m_led[1], 1'b1);
      total++;
      if ({d_ovr[1], d_act[1], d_led[1], d_sc[1], d_tl[1]} !== {1'b1, 1'b0, 5'd0, 7'd2, 7'd0}) begin
         bad++;
         $display("FAIL final_tick_hit got over=%b act=%b led=%b score=%0d tl=%0d want 1 0 0 2 0",
                  d_ovr[1], d_act[1], d_led[1], d_sc[1], d_tl[1]);
      end
      cyc(1'b0, 5'd0, 1'b1);
      cyc(1'b0, 5'b11111, 1'b1);
      cyc(1'b0, 5'd0, 1'b0);
      total++;
      if ({d_ovr[1], d_sc[1], d_tl[1], d_led[1]} !== {1'b1, 7'd2, 7'd0, 5'd0}) begin
         bad++;
         $display("FAIL over_hold got over=%b score=%0d tl=%0d led=%b want 1 2 0 0",
                  d_ovr[1], d_sc[1], d_tl[1], d_led[1]);
      end
      cyc(1'b1, 5'd0, 1'b0);
      total++;
      if ({d_sc[1], d_tl[1], d_act[1], d_ovr[1]} !== {7'd0, 7'd3, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL restart got score=%0d tl=%0d act=%b over=%b want 0 3 1 0",
                  d_sc[1], d_tl[1], d_act[1], d_ovr[1]);
      end
      cyc(1'b0, 5'd0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         total++;
         if ({d_led[k], d_sc[k], d_tl[k], d_act[k], d_ovr[k]} !== exp_out(k)) begin
            bad++;
            $display("FAIL over_model[%0d] got=%h want=%h", k,
                     {d_led[k], d_sc[k], d_tl[k], d_act[k], d_ovr[k]}, exp_out(k));
         end
      end
   endtask

   // Reset, start, then five hits; run 0 records the model's mole sequence, run 1 checks against it.
   task automatic play_script(input int run);
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (3) cyc(1'b0, 5'd0, 1'b0);
      cyc(1'b1, 5'd0, 1'b0);
      cyc(1'b0, 5'd0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (run == 0) mseq[i] = m_led[0];
         total++;
         if (d_led[0] !== mseq[i]) begin
            bad++;
            $display("FAIL script_run%0d_mole%0d got=%b want=%b", run, i, d_led[0], mseq[i]);
         end
         cyc(1'b0, mseq[i], 1'b0);
         cyc(1'b0, 5'd0, 1'b1);
         cyc(1'b0, 5'd0, 1'b0);
      end
   endtask

   task automatic test_reset_mid();
      play_script(0);
      total++;
      if ({d_sc[0], d_led[0] != 5'd0} !== {7'd5, 1'b1}) begin
         bad++;
         $display("FAIL pre_abort got score=%0d led=%b want score=5 lit", d_sc[0], d_led[0]);
      end
      #3;
      reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         total++;
         if ({d_led[k], d_sc[k], d_tl[k], d_act[k], d_ovr[k]} !== 21'd0) begin
            bad++;
            $display("FAIL async_abort[%0d] got=%h want=0", k,
                     {d_led[k], d_sc[k], d_tl[k], d_act[k], d_ovr[k]});
         end
      end
      @(posedge clock);
      #1;
      play_script(1);
   endtask

   task automatic test_random();
      logic       s;
      logic       t;
      logic [4:0] b;
      int         r;
      for (int n = 0; n < 3000; n++) begin
         s = ($urandom_range(0, 39) == 0);
         t = ($urandom_range(0, 3) == 0);
         r = $urandom_range(0, 3);
         b = (r == 0) ? m_led[0] : (r == 1) ? 5'($urandom) : 5'd0;
         cyc(s, b, t);
         for (int k = 0; k < 2; k++) begin
            total++;
            if ({d_led[k], d_sc[k], d_tl[k], d_act[k], d_ovr[k]} !== exp_out(k)) begin
               bad++;
               $display("FAIL random[%0d] cycle=%0d got led=%b sc=%0d tl=%0d act=%b ovr=%b want=%h",
                        k, n, d_led[k], d_sc[k], d_tl[k], d_act[k], d_ovr[k], exp_out(k));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_start_hit();
      test_miss();
      test_wrong();
      test_both_held();
      test_game_over();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mole_game_controller.md
Name: mole_game_controller

Overview:
- Game sequencer for the whack-a-mole board.
- Runs an FSM that picks a mole pseudo-randomly, lights its LED and times its exposure. It also scores button hits and counts down the round.
- Advances on a 1-cycle `tick` enable, which the top level derives from the 1 Hz divider output.
- Its `score` and `timeLeft` outputs feed the 1 kHz segment-display driver.

Parameters:
- GAME_SECONDS, 30, round length in ticks; range 1..99.
- MOLE_TICKS, 2, ticks a mole stays lit before counting as a miss; range 1..15.
- LFSR_SEED, 8'hA5, reset value of the selection LFSR; must be nonzero.

Ports:
- clock  input  1  100 MHz system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low; clears all state.
- tick  input  1  one-clock-wide pulse at 1 Hz, synchronous to `clock`.
- startButton  input  1  debounced, synchronised level.
- moleButton  input  5  debounced, synchronised levels; bit i pairs with moleLED[i].
- moleLED  output  5  one-hot active mole, or all zero.
- score  output  7  hits, binary 0..99.
- timeLeft  output  7  remaining round seconds, binary.
- gameActive  output  1  high in SPAWN, UP and GAP.
- gameOver  output  1  high in OVER.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; moleLED = 0, score = 0, timeLeft = 0, gameActive = 0, gameOver = 0.
  - LFSR = LFSR_SEED; button edge registers = 0.
- Edge detection:
  - `startButton` and each `moleButton` bit are registered once.
  - "press" = current & ~previous, one cycle long.
  - A held button generates exactly one press.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4; shifts every clock in every state.
  - Never reaches zero.
- Mole index selection, done in SPAWN:
  - v = lfsr[2:0]; idx = (v >= 5) ? v - 5 : v.
  - If idx equals the previous mole index, use idx + 1, wrapping 4 to 0.
  - The previous index resets to 0.
- State IDLE:
  - Outputs are zero.
  - Start press: score = 0, timeLeft = GAME_SECONDS, go to SPAWN.
- State SPAWN (one cycle):
  - Latch idx; moleLED = one-hot(idx); moleTimer = MOLE_TICKS; go to UP.
- State UP:
  - Correct press (`moleButton[idx]`): score += 1, saturating at 99; moleLED = 0; go to GAP.
  - Wrong press (any other bit) with no correct press in the same cycle: score -= 1, floor at 0; stay in UP.
  - Correct and wrong presses in the same cycle: correct wins, no penalty.
  - Tick: moleTimer -= 1. When it reaches 0: miss, moleLED = 0, go to GAP; score unchanged.
- State GAP:
  - LEDs off; presses ignored.
  - Next tick: go to SPAWN.
- Round timer:
  - On every tick in SPAWN, UP or GAP: timeLeft -= 1.
  - The transition that makes timeLeft 0 goes to OVER. It overrides the transition of the current state.
  - A hit or penalty in that same cycle is still applied to score.
- State OVER:
  - moleLED = 0, gameOver = 1; score and timeLeft (0) held.
  - Start press: score = 0, timeLeft = GAME_SECONDS, go to SPAWN.
- Start presses in SPAWN, UP or GAP are ignored.
- `moleLED` and all other outputs are registered; latency is 1 clock from the causing press or tick.
- Reset asserted mid-game aborts immediately to the reset values; no partial score survives.

Test Plan:
- Reset low, then high, 10 idle clocks -> moleLED = 0, score = 0, timeLeft = 0, gameActive = 0, gameOver = 0.
- Start press -> 2 clocks later moleLED is one-hot; timeLeft = 30, gameActive = 1. Press the lit bit for 1 clock -> score = 1, moleLED = 0 on the next clock; the next tick relights a different bit.
- Mole lit, 2 ticks with no press -> moleLED = 0 after the 2nd tick, score unchanged. Wrong button pressed at score = 0 -> score stays 0. Wrong button at score = 3 -> 2.
- Correct and wrong bits rising in the same cycle -> score +1 only. Correct button held 5 clocks -> only +1.
- GAME_SECONDS = 3, 3 ticks -> gameOver = 1, moleLED = 0, score held. Hit coincident with the final tick -> counted. Start press -> score = 0, timeLeft = 3.
- Reset pulsed mid-UP with score = 5 -> all outputs zero asynchronously; the sequence after release matches the first run, because the LFSR restarts from LFSR_SEED.
